l2_ddr_refill_ctrl: RTL and testbench
=====================================

Name: l2_ddr_refill_ctrl

Overview:
- Streams 128-bit beats from the DDR application read interface into the DDR-side port of the L2 cache, keeping the 4096x16 L2 buffer topped up for L1 consumption.
- Issues fixed-length read bursts when L2 free space allows, buffers returning beats in a small FIFO, and writes them into L2 when the L1/DDR conflict flag is clear.
- Sits between the DDR controller app interface and the L2 cache; it drives the L2 cache's i_ddr_operate_enable, i_ddr_rw and io_ddr_data_bus.

Parameters:
- BURST_BEATS, 8: 128-bit beats per DDR read command; power of two, 1..16.
- FIFO_DEPTH, 16: beat FIFO entries; power of two, >= BURST_BEATS.
- ADDR_W, 28: DDR byte address width.

Ports:
- clk_166M66  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- i_enable  in  1  level; refill allowed while high.
- i_base_addr  in  ADDR_W  start byte address, 16-byte aligned; loaded while idle and disabled.
- i_l2_unread_size  in  12  L2 unread count, in 16-bit words.
- i_l1ddr_rw_confilicts  in  1  L2 conflict flag; blocks L2 writes.
- o_app_cmd_valid  out  1  DDR read command valid.
- i_app_cmd_ready  in  1  DDR command accepted.
- o_app_addr  out  ADDR_W  DDR read byte address.
- i_app_rd_valid  in  1  returned beat valid; no backpressure.
- i_app_rd_data  in  128  returned beat.
- o_ddr_operate_enable  out  1  L2 DDR-port enable.
- o_ddr_rw  out  1  L2 DDR-port direction; 1 = write into L2.
- o_ddr_wdata  out  128  beat presented to L2.
- o_busy  out  1  burst outstanding or FIFO non-empty.
- o_bursts_done  out  16  completed bursts; wraps.
- o_err_unexpected  out  1  sticky; a beat arrived with no burst outstanding.

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; beat counter 0; cur_addr 0.
- Address load: in IDLE with i_enable = 0, cur_addr <= i_base_addr on every cycle.
- free_beats = (12'hFFF - i_l2_unread_size) >> 3.
- Issue condition: free_beats >= BURST_BEATS + fifo_count + 1. The +1 covers the one-cycle lag of the L2 size readout.
- FIFO space rule: FIFO_DEPTH - fifo_count >= BURST_BEATS also required, so the FIFO never overflows.
- IDLE: move to ISSUE when i_enable = 1 and both conditions hold.
- ISSUE: o_app_cmd_valid = 1 and o_app_addr = cur_addr, held stable until i_app_cmd_ready.
  - On ready: cur_addr <= cur_addr + BURST_BEATS*16, wrapping mod 2^ADDR_W; beat counter cleared; go to WAIT.
  - i_enable falling during ISSUE does not withdraw the command.
- WAIT: each i_app_rd_valid pushes i_app_rd_data into the FIFO and increments the beat counter.
  - When the counter reaches BURST_BEATS: o_bursts_done++ and return to IDLE.
  - Exactly one burst is outstanding at a time.
  - Disable mid-burst: all remaining beats are still accepted and written before going idle.
- Unexpected beat: i_app_rd_valid outside WAIT drops the data and sets o_err_unexpected. Only rst clears it.
- Drain path (independent of the FSM): each cycle with FIFO non-empty and i_l1ddr_rw_confilicts = 0:
  - pop one beat;
  - the same cycle, assert o_ddr_operate_enable = 1 and o_ddr_rw = 1 with o_ddr_wdata = popped beat (combinational from FIFO head).
  - Otherwise o_ddr_operate_enable = 0 and o_ddr_rw = 0. o_ddr_wdata then shows the FIFO head, or 0 when empty.
  - Throughput: one beat per cycle.
- Simultaneous push and pop: fifo_count is unchanged; a push into an empty FIFO is visible to the pop no earlier than the next cycle.
- Conflict asserted: drain stalls, beats accumulate; the space rule guarantees they fit.
- Reset mid-operation: FIFO flushed, burst abandoned, state IDLE next cycle. The DDR controller is reset on the same rst.
- o_busy = (state != IDLE) | (fifo_count != 0).

Decomposition:
- Shared package l2_pkg:
  - L2_WORDS = 4096;
  - L2_BEAT_WORDS = 8;
  - DDR_BEAT_BYTES = 16;
  - state enum {IDLE, ISSUE, WAIT}.
- Sub-module: l2_beat_fifo, a synchronous FWFT FIFO with 128-bit width, depth FIFO_DEPTH, outputs count/empty/full, synchronous reset.

Test Plan:
- Basic refill: unread = 0, base = 0x100, enable → cmd at addr 0x100. After ready, 8 beats are written to L2 on consecutive cycles; o_bursts_done = 1. The next cmd is at addr 0x180.
- Near full: unread = 12'hF80 (free_beats = 15) with fifo_count = 8 → no issue. Lower unread to 12'hF00 (free_beats = 31) → cmd issued.
- Conflict stall: hold conflict high during a burst → o_ddr_operate_enable stays 0 and fifo_count reaches 8. Release → 8 consecutive writes with data in arrival order.
- Disable mid-burst: drop i_enable after beat 3 → beats 4-8 are still accepted and written, then IDLE with o_busy = 0. Re-enable → cmd at the new i_base_addr.
- Unexpected beat: i_app_rd_valid in IDLE → data not written; o_err_unexpected = 1 and stays set until rst.
- Reset mid-burst / wrap: rst after beat 5 → outputs 0 and FIFO empty next cycle. Base = 2^28 - 0x80 → second cmd at addr 0x0.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared definitions for the L2 DDR refill path: L2 geometry, DDR beat size,
// refill FSM states and the free-space helper.
package l2_pkg;

  localparam int L2_WORDS       = 4096;
  localparam int L2_BEAT_WORDS  = 8;
  localparam int DDR_BEAT_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Whole 128-bit beats that still fit in L2, given the unread 16-bit word count.
  function automatic logic [11:0] free_beats_f(input logic [11:0] unread_words);
    free_beats_f = (12'(L2_WORDS - 1) - unread_words) >> $clog2(L2_BEAT_WORDS);
  endfunction

endpackage

// File: rtl/l2_beat_fifo.sv
// First-word-fall-through beat FIFO. The head entry is visible on dout
// whenever the FIFO is non-empty; a push into an empty FIFO becomes poppable
// on the following cycle.
module l2_beat_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == (AW + 1)'(0));
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointer and occupancy values from the accepted push/pop pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Beat storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/l2_ddr_refill_ctrl.sv
// Refill controller: issues one fixed-length DDR read burst at a time while
// L2 has room, buffers the returning beats and streams them into the L2
// DDR-side write port whenever L1 is not using the buffer.
module l2_ddr_refill_ctrl
  import l2_pkg::*;
#(
  parameter int BURST_BEATS = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_W      = 28
) (
  input  logic              clk_166M66,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [11:0]       i_l2_unread_size,
  input  logic              i_l1ddr_rw_confilicts,
  output logic              o_app_cmd_valid,
  input  logic              i_app_cmd_ready,
  output logic [ADDR_W-1:0] o_app_addr,
  input  logic              i_app_rd_valid,
  input  logic [127:0]      i_app_rd_data,
  output logic              o_ddr_operate_enable,
  output logic              o_ddr_rw,
  output logic [127:0]      o_ddr_wdata,
  output logic              o_busy,
  output logic [15:0]       o_bursts_done,
  output logic              o_err_unexpected
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BURST_BEATS) + 1;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_BEATS * DDR_BEAT_BYTES);
  localparam logic [BW-1:0]     LAST_BEAT   = BW'(BURST_BEATS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [15:0]       bursts_q, bursts_d;
  logic              err_q, err_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  logic              fifo_push, fifo_pop, beat_accept;
  logic [127:0]      fifo_head;
  logic [12:0]       free_beats, need_beats;
  logic [CW-1:0]     fifo_space;
  logic              can_issue;

  // Issue gate: L2 must hold a whole burst on top of what is already buffered
  // plus one beat of slack for the lagging size readout, and the FIFO must
  // have room for the full burst.
  always_comb begin
    free_beats = {1'b0, free_beats_f(i_l2_unread_size)};
    need_beats = 13'(BURST_BEATS) + 13'(fifo_count) + 13'd1;
    fifo_space = CW'(FIFO_DEPTH) - fifo_count;
    can_issue  = (free_beats >= need_beats) && (fifo_space >= CW'(BURST_BEATS));
  end

  // Refill FSM next state, address walk, beat counting and error capture.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    beat_cnt_d  = beat_cnt_q;
    bursts_d    = bursts_q;
    beat_accept = 1'b0;
    err_d       = err_q | (i_app_rd_valid & (state_q != WAIT));
    case (state_q)
      IDLE: begin
        if (!i_enable) begin
          cur_addr_d = i_base_addr;
        end else if (can_issue) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (i_app_cmd_ready) begin
          cur_addr_d = cur_addr_q + BURST_BYTES;
          beat_cnt_d = '0;
          state_d    = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (i_app_rd_valid) begin
          beat_accept = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            bursts_d   = bursts_q + 16'd1;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and bookkeeping registers.
  always_ff @(posedge clk_166M66) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      beat_cnt_q <= '0;
      bursts_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      beat_cnt_q <= beat_cnt_d;
      bursts_q   <= bursts_d;
      err_q      <= err_d;
    end
  end

  assign fifo_push = beat_accept & ~fifo_full;
  assign fifo_pop  = ~fifo_empty & ~i_l1ddr_rw_confilicts;

  l2_beat_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(128)
  ) u_fifo (
    .clk  (clk_166M66),
    .rst  (rst),
    .push (fifo_push),
    .din  (i_app_rd_data),
    .pop  (fifo_pop),
    .dout (fifo_head),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign o_app_cmd_valid      = (state_q == ISSUE);
  assign o_app_addr           = (state_q == ISSUE) ? cur_addr_q : '0;
  assign o_ddr_operate_enable = fifo_pop;
  assign o_ddr_rw             = fifo_pop;
  assign o_ddr_wdata          = fifo_empty ? 128'd0 : fifo_head;
  assign o_busy               = (state_q != IDLE) | ~fifo_empty;
  assign o_bursts_done        = bursts_q;
  assign o_err_unexpected     = err_q;

endmodule

// File: tb/tb_l2_ddr_refill_ctrl.sv
// Self-checking bench for l2_ddr_refill_ctrl: every beat handed to the DUT
// is queued as an expected L2 write and checked when the DUT writes it.
module tb_l2_ddr_refill_ctrl;

  logic         clk_166M66 = 1'b0;
  logic         rst = 1'b1;
  logic         i_enable = 1'b0;
  logic [27:0]  i_base_addr = 28'd0;
  logic [11:0]  i_l2_unread_size = 12'd0;
  logic         i_l1ddr_rw_confilicts = 1'b0;
  logic         o_app_cmd_valid;
  logic         i_app_cmd_ready = 1'b0;
  logic [27:0]  o_app_addr;
  logic         i_app_rd_valid = 1'b0;
  logic [127:0] i_app_rd_data = 128'd0;
  logic         o_ddr_operate_enable;
  logic         o_ddr_rw;
  logic [127:0] o_ddr_wdata;
  logic         o_busy;
  logic [15:0]  o_bursts_done;
  logic         o_err_unexpected;

  int           errors = 0;
  int           checks = 0;
  int           writes = 0;
  int           exp_bursts = 0;
  logic [127:0] exp_q[$];

  typedef struct {
    logic [11:0] unread;
    logic        exp_issue;
  } issue_vec_t;

  always #3 clk_166M66 = ~clk_166M66;

  l2_ddr_refill_ctrl dut (
    .clk_166M66           (clk_166M66),
    .rst                  (rst),
    .i_enable             (i_enable),
    .i_base_addr          (i_base_addr),
    .i_l2_unread_size     (i_l2_unread_size),
    .i_l1ddr_rw_confilicts(i_l1ddr_rw_confilicts),
    .o_app_cmd_valid      (o_app_cmd_valid),
    .i_app_cmd_ready      (i_app_cmd_ready),
    .o_app_addr           (o_app_addr),
    .i_app_rd_valid       (i_app_rd_valid),
    .i_app_rd_data        (i_app_rd_data),
    .o_ddr_operate_enable (o_ddr_operate_enable),
    .o_ddr_rw             (o_ddr_rw),
    .o_ddr_wdata          (o_ddr_wdata),
    .o_busy               (o_busy),
    .o_bursts_done        (o_bursts_done),
    .o_err_unexpected     (o_err_unexpected)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // One clock: L2 writes are scoreboarded on the falling edge, then the
  // bench resumes 1 ns after the rising edge to drive/sample.
  task automatic tick();
    logic [127:0] exp;
    @(negedge clk_166M66);
    if (!rst && o_ddr_operate_enable) begin
      writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL l2_write_unexpected: got write of %0h, required no write", o_ddr_wdata);
      end else begin
        exp = exp_q.pop_front();
        chk("l2_wdata", o_ddr_wdata, exp);
        chk("l2_rw", o_ddr_rw, 1'b1);
      end
    end
    @(posedge clk_166M66);
    #1;
  endtask

  task automatic send_beats(input int n, input logic [127:0] seed, input bit drain_on);
    for (int i = 0; i < n; i++) begin
      i_app_rd_valid = 1'b1;
      i_app_rd_data  = seed + 128'(i);
      exp_q.push_back(seed + 128'(i));
      tick();
      if (drain_on) chk("drain_consecutive", o_ddr_operate_enable, 1'b1);
    end
    i_app_rd_valid = 1'b0;
  endtask

  task automatic wait_cmd(input logic [27:0] addr, input string name);
    int n = 0;
    while (!o_app_cmd_valid && n < 30) begin
      tick();
      n++;
    end
    if (!o_app_cmd_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no command, required command at %0h", name, addr);
    end else begin
      chk({name, "_addr"}, o_app_addr, addr);
      tick();
      tick();
      chk({name, "_hold_valid"}, o_app_cmd_valid, 1'b1);
      chk({name, "_hold_addr"}, o_app_addr, addr);
      i_app_cmd_ready = 1'b1;
      tick();
      i_app_cmd_ready = 1'b0;
      chk({name, "_accepted"}, o_app_cmd_valid, 1'b0);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 60) begin
      tick();
      n++;
    end
    chk(name, o_busy, 1'b0);
  endtask

  initial begin
    issue_vec_t vecs[6];
    vecs[0] = '{unread: 12'h000, exp_issue: 1'b1};
    vecs[1] = '{unread: 12'hFB7, exp_issue: 1'b1};  // free 9 == 8 + 0 + 1
    vecs[2] = '{unread: 12'hFB8, exp_issue: 1'b0};  // free 8
    vecs[3] = '{unread: 12'hFFF, exp_issue: 1'b0};  // free 0
    vecs[4] = '{unread: 12'hF80, exp_issue: 1'b1};  // free 15, FIFO empty
    vecs[5] = '{unread: 12'h800, exp_issue: 1'b1};

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_cmd_valid", o_app_cmd_valid, 1'b0);
    chk("rst_app_addr", o_app_addr, 28'd0);
    chk("rst_oe", o_ddr_operate_enable, 1'b0);
    chk("rst_rw", o_ddr_rw, 1'b0);
    chk("rst_wdata", o_ddr_wdata, 128'd0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_bursts", o_bursts_done, 16'd0);
    chk("rst_err", o_err_unexpected, 1'b0);

    // Basic refill with back-to-back bursts
    i_base_addr = 28'h100;
    tick();
    i_enable = 1'b1;
    wait_cmd(28'h100, "basic_cmd0");
    send_beats(8, 128'hA000_0000_0000_0000_0000_0000_0000_0000, 1'b1);
    exp_bursts++;
    chk("basic_bursts1", o_bursts_done, 16'(exp_bursts));
    wait_cmd(28'h180, "basic_cmd1");
    i_enable = 1'b0;
    send_beats(8, 128'hB111_0000_0000_0000_0000_0000_0000_0000, 1'b1);
    exp_bursts++;
    chk("basic_bursts2", o_bursts_done, 16'(exp_bursts));
    wait_idle("basic_idle");
    chk("basic_write_count", 128'(writes), 128'd16);

    // Issue decision table from IDLE with an empty FIFO
    for (int v = 0; v < 6; v++) begin
      i_enable = 1'b0;
      i_l2_unread_size = vecs[v].unread;
      tick();
      i_enable = 1'b1;
      tick();
      tick();
      chk($sformatf("issue_u%03h", vecs[v].unread), o_app_cmd_valid, vecs[v].exp_issue);
      if (vecs[v].exp_issue) exp_bursts++;
      if (o_app_cmd_valid) begin
        i_app_cmd_ready = 1'b1;
        tick();
        i_app_cmd_ready = 1'b0;
        i_enable = 1'b0;
        send_beats(8, 128'hC000 + 128'(v * 256), 1'b1);
      end
      i_enable = 1'b0;
      wait_idle("table_idle");
    end
    chk("table_bursts", o_bursts_done, 16'(exp_bursts));
    i_l2_unread_size = 12'd0;

    // Near full with 8 beats held by the conflict flag, then release
    i_base_addr = 28'h1000;
    tick();
    i_l1ddr_rw_confilicts = 1'b1;
    i_enable = 1'b1;
    wait_cmd(28'h1000, "nf_cmd0");
    i_l2_unread_size = 12'hF80;
    send_beats(8, 128'hD000, 1'b0);
    exp_bursts++;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nf_no_issue", o_app_cmd_valid, 1'b0);
      chk("stall_no_write", o_ddr_operate_enable, 1'b0);
    end
    chk("stall_busy", o_busy, 1'b1);
    chk("stall_head", o_ddr_wdata, exp_q[0]);
    i_l2_unread_size = 12'hF00;
    tick();
    tick();
    chk("nf_issue", o_app_cmd_valid, 1'b1);
    i_l1ddr_rw_confilicts = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("release_consecutive", o_ddr_operate_enable, 1'b1);
      tick();
    end
    chk("release_drained", o_ddr_operate_enable, 1'b0);
    wait_cmd(28'h1080, "nf_cmd1");
    i_enable = 1'b0;
    i_l2_unread_size = 12'd0;
    send_beats(8, 128'hE000, 1'b1);
    exp_bursts++;
    wait_idle("nf_idle");

    // Disable after beat 3, then re-enable at a new base
    i_base_addr = 28'h4000;
    tick();
    i_enable = 1'b1;
    wait_cmd(28'h4000, "dis_cmd");
    send_beats(3, 128'hF000, 1'b1);
    i_enable = 1'b0;
    i_base_addr = 28'h8000;
    send_beats(5, 128'hF003, 1'b1);
    exp_bursts++;
    wait_idle("dis_idle");
    chk("dis_bursts", o_bursts_done, 16'(exp_bursts));
    tick();
    i_enable = 1'b1;
    wait_cmd(28'h8000, "reen_cmd");
    i_enable = 1'b0;
    send_beats(8, 128'h1_0000, 1'b1);
    exp_bursts++;
    wait_idle("reen_idle");

    // Unexpected beat in IDLE
    i_app_rd_valid = 1'b1;
    i_app_rd_data  = 128'hDEAD_BEEF;
    tick();
    i_app_rd_valid = 1'b0;
    chk("unexp_err_set", o_err_unexpected, 1'b1);
    repeat (3) tick();
    chk("unexp_err_sticky", o_err_unexpected, 1'b1);
    chk("unexp_not_buffered", o_busy, 1'b0);
    chk("unexp_bursts", o_bursts_done, 16'(exp_bursts));

    // Reset after beat 5, then address wrap
    i_base_addr = 28'hFFF_FF80;
    tick();
    i_enable = 1'b1;
    wait_cmd(28'hFFF_FF80, "rstm_cmd");
    send_beats(5, 128'h2_0000, 1'b1);
    rst = 1'b1;
    i_enable = 1'b0;
    exp_q.delete();
    tick();
    chk("rstm_busy", o_busy, 1'b0);
    chk("rstm_cmd_valid", o_app_cmd_valid, 1'b0);
    chk("rstm_oe", o_ddr_operate_enable, 1'b0);
    chk("rstm_wdata", o_ddr_wdata, 128'd0);
    chk("rstm_bursts", o_bursts_done, 16'd0);
    chk("rstm_err", o_err_unexpected, 1'b0);
    rst = 1'b0;
    exp_bursts = 0;
    tick();
    i_enable = 1'b1;
    wait_cmd(28'hFFF_FF80, "wrap_cmd0");
    send_beats(8, 128'h3_0000, 1'b1);
    wait_cmd(28'h000_0000, "wrap_cmd1");
    i_enable = 1'b0;
    send_beats(8, 128'h4_0000, 1'b1);
    wait_idle("wrap_idle");
    chk("wrap_bursts", o_bursts_done, 16'd2);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
